mem_port_arbiter: RTL and testbench

Sequences the single shared memory port of the multicycle CPU between two requesters: the CPU memory path (instruction fetch plus lw/sw) and a DMA/debug master. It runs one transaction at a time through a req/done handshake and hides variable memory latency behind a per-requester done pulse. A timeout guard ends any access the memory never completes. It sits between the multicycle control unit's memory strobes and the memory model.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_if.sv | 53 +++++
 rtl/mem_port_arbiter_rr_arb2.sv | 25 ++
 rtl/mem_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Provides the arbiter FSM state enum, owner encoding and a counter-width helper.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ArbIdle = 2'd0,
      ArbBusy = 2'd1,
      ArbResp = 2'd2
   } arb_state_t;

   typedef logic owner_t;

   localparam owner_t OwnCpu = 1'b0;
   localparam owner_t OwnDma = 1'b1;

   // Bits needed to count 0 .. timeout-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned timeout);
      return (timeout > 1) ? $clog2(timeout) : 1;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the arbiter's requester and memory-side signals.
// Ports: cpu_* / dma_* requester handshakes (req, wr, addr, wdata in; gnt, done,
// err, rdata out) and the shared memory port (mem_rd, mem_wr, mem_addr,
// mem_wdata out; mem_rdata, mem_ready in).
// slave  : the arbiter's view.  master : requesters plus memory model.
interface mem_port_arbiter_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic          cpu_req;
   logic          cpu_wr;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_gnt;
   logic          cpu_done;
   logic          cpu_err;
   logic [DW-1:0] cpu_rdata;

   logic          dma_req;
   logic          dma_wr;
   logic [AW-1:0] dma_addr;
   logic [DW-1:0] dma_wdata;
   logic          dma_gnt;
   logic          dma_done;
   logic          dma_err;
   logic [DW-1:0] dma_rdata;

   logic          mem_rd;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;

   modport slave (
      input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
      output cpu_gnt, cpu_done, cpu_err, cpu_rdata,
      input  dma_req, dma_wr, dma_addr, dma_wdata,
      output dma_gnt, dma_done, dma_err, dma_rdata,
      output mem_rd, mem_wr, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport master (
      output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
      input  cpu_gnt, cpu_done, cpu_err, cpu_rdata,
      output dma_req, dma_wr, dma_addr, dma_wdata,
      input  dma_gnt, dma_done, dma_err, dma_rdata,
      input  mem_rd, mem_wr, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker (rr_arb2).
// Ports: req[1:0] (bit 0 = cpu, bit 1 = dma), last (previous winner) in;
// valid (any request) and owner (chosen requester) out.
module mem_port_arbiter_rr_arb2
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  owner_t     last,
   output logic       valid,
   output owner_t     owner
);

   // A lone requester wins; on a tie the one that did not win last goes.
   always_comb begin
      valid = |req;
      owner = OwnCpu;
      case (req)
         2'b01:   owner = OwnCpu;
         2'b10:   owner = OwnDma;
         2'b11:   owner = ~last;
         default: owner = OwnCpu;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences the single shared memory port between the CPU memory path and a
// DMA/debug master, one transaction at a time, with a BUSY-cycle timeout.
// Ports: clk, reset (synchronous, active-high); bus (slave modport) carrying
// both requester handshakes and the memory strobes/data. Every output comes
// straight from a register.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned AW      = 32,
   parameter int unsigned DW      = 32
)
(
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);

   localparam int unsigned   CW      = cnt_width(TIMEOUT);
   localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);

   arb_state_t    state;
   owner_t        last_owner;
   owner_t        owner_q;
   logic [CW-1:0] cnt;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          mem_rd_q;
   logic          mem_wr_q;
   logic          cpu_gnt_q, cpu_done_q, cpu_err_q;
   logic          dma_gnt_q, dma_done_q, dma_err_q;
   logic [DW-1:0] cpu_rdata_q, dma_rdata_q;

   logic [1:0]    req_vec;
   logic          pick_valid;
   owner_t        pick_owner;
   logic          sel_wr;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   assign req_vec = {bus.dma_req, bus.cpu_req};

   mem_port_arbiter_rr_arb2 u_rr_arb2 (
      .req   (req_vec),
      .last  (last_owner),
      .valid (pick_valid),
      .owner (pick_owner)
   );

   // Command of whichever requester the picker selects this cycle.
   always_comb begin
      sel_wr    = bus.cpu_wr;
      sel_addr  = bus.cpu_addr;
      sel_wdata = bus.cpu_wdata;
      if (pick_owner == OwnDma) begin
         sel_wr    = bus.dma_wr;
         sel_addr  = bus.dma_addr;
         sel_wdata = bus.dma_wdata;
      end
   end

   // FSM, command latches, timeout counter and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ArbIdle;
         last_owner  <= OwnDma;
         owner_q     <= OwnCpu;
         cnt         <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         cpu_gnt_q   <= 1'b0;
         cpu_done_q  <= 1'b0;
         cpu_err_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dma_gnt_q   <= 1'b0;
         dma_done_q  <= 1'b0;
         dma_err_q   <= 1'b0;
         dma_rdata_q <= '0;
      end else begin
         case (state)
            ArbIdle: begin
               if (pick_valid) begin
                  owner_q    <= pick_owner;
                  last_owner <= pick_owner;
                  addr_q     <= sel_addr;
                  wdata_q    <= sel_wdata;
                  cnt        <= '0;
                  mem_rd_q   <= ~sel_wr;
                  mem_wr_q   <= sel_wr;
                  cpu_gnt_q  <= (pick_owner == OwnCpu);
                  dma_gnt_q  <= (pick_owner == OwnDma);
                  state      <= ArbBusy;
               end
            end
            ArbBusy: begin
               // mem_ready takes priority over the final timeout cycle.
               if (bus.mem_ready || (cnt == CntLast)) begin
                  mem_rd_q <= 1'b0;
                  mem_wr_q <= 1'b0;
                  if (owner_q == OwnCpu) begin
                     cpu_done_q  <= 1'b1;
                     cpu_err_q   <= ~bus.mem_ready;
                     cpu_rdata_q <= bus.mem_ready ? bus.mem_rdata : '0;
                  end else begin
                     dma_done_q  <= 1'b1;
                     dma_err_q   <= ~bus.mem_ready;
                     dma_rdata_q <= bus.mem_ready ? bus.mem_rdata : '0;
                  end
                  state <= ArbResp;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ArbResp: begin
               cpu_gnt_q   <= 1'b0;
               cpu_done_q  <= 1'b0;
               cpu_err_q   <= 1'b0;
               cpu_rdata_q <= '0;
               dma_gnt_q   <= 1'b0;
               dma_done_q  <= 1'b0;
               dma_err_q   <= 1'b0;
               dma_rdata_q <= '0;
               state       <= ArbIdle;
            end
            default: state <= ArbIdle;
         endcase
      end
   end

   assign bus.mem_rd    = mem_rd_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.cpu_gnt   = cpu_gnt_q;
   assign bus.cpu_done  = cpu_done_q;
   assign bus.cpu_err   = cpu_err_q;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.dma_gnt   = dma_gnt_q;
   assign bus.dma_done  = dma_done_q;
   assign bus.dma_err   = dma_err_q;
   assign bus.dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected
// memory bursts and done pulses; a monitor/memory model pops and compares.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int unsigned TO   = 4;
   localparam logic [31:0] Junk = 32'hBAD0_0BAD;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          lat;
      int          len;
   } mem_exp_t;

   typedef struct packed {
      logic        own;
      logic        err;
      logic        chk_rd;
      logic [31:0] rdata;
   } done_exp_t;

   logic clk = 1'b0;
   logic reset;

   mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_port_arbiter #(.TIMEOUT(TO), .AW(32), .DW(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   mem_exp_t  exp_mem_q[$];
   done_exp_t exp_done_q[$];
   req_t      cpu_seq[4];
   req_t      dma_seq[4];
   int        vec_cnt  = 0;
   int        fail_cnt = 0;
   bit        stop_mon = 1'b0;
   int        burst_n  = 0;
   bit        have_cur = 1'b0;
   mem_exp_t  cur;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // lat = BUSY cycle carrying mem_ready (0 = never); len = expected strobe cycles.
   task automatic push_txn(input logic own, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int lat, input int len, input bit with_done,
                           input logic err, input logic [31:0] done_rdata);
      mem_exp_t  m;
      done_exp_t d;
      m.wr = wr; m.addr = addr; m.wdata = wdata; m.rdata = rdata;
      m.lat = lat; m.len = len;
      exp_mem_q.push_back(m);
      if (with_done) begin
         d.own = own; d.err = err; d.chk_rd = ~wr | err; d.rdata = done_rdata;
         exp_done_q.push_back(d);
      end
   endtask

   task automatic load(input logic own, input int idx);
      if (own == OwnCpu) begin
         bus.cpu_wr = cpu_seq[idx].wr; bus.cpu_addr = cpu_seq[idx].addr;
         bus.cpu_wdata = cpu_seq[idx].wdata;
      end else begin
         bus.dma_wr = dma_seq[idx].wr; bus.dma_addr = dma_seq[idx].addr;
         bus.dma_wdata = dma_seq[idx].wdata;
      end
   endtask

   task automatic set_req(input logic own, input logic v);
      if (own == OwnCpu) bus.cpu_req = v;
      else               bus.dma_req = v;
   endtask

   // Holds req across n transactions, reloading the command after each done.
   task automatic requester(input logic own, input int n);
      int got = 0;
      int waited = 0;
      load(own, 0);
      set_req(own, 1'b1);
      while (got < n && waited < 100) begin
         @(negedge clk);
         waited++;
         if ((own == OwnCpu) ? bus.cpu_done : bus.dma_done) begin
            got++;
            if (got < n) load(own, got);
            else         set_req(own, 1'b0);
         end
      end
      if (got < n) set_req(own, 1'b0);
      check((own == OwnCpu) ? "cpu_txn_count" : "dma_txn_count", 32'(got), 32'(n));
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_flags"}, 32'({bus.cpu_gnt, bus.cpu_done, bus.cpu_err, bus.dma_gnt,
                                  bus.dma_done, bus.dma_err, bus.mem_rd, bus.mem_wr}), 32'h0);
      check({tag, "_cpu_rdata"}, bus.cpu_rdata, 32'h0);
      check({tag, "_dma_rdata"}, bus.dma_rdata, 32'h0);
      check({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
      check({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Memory model plus done-pulse scoreboard, evaluated once per negedge.
   task automatic mon_step();
      done_exp_t de;
      logic      own_act;
      logic      rdy;
      rdy = 1'b0;
      if (bus.mem_rd || bus.mem_wr) begin
         if (burst_n == 0) begin
            if (exp_mem_q.size() == 0) begin
               have_cur = 1'b0;
               check("unexpected_burst", 32'({bus.mem_rd, bus.mem_wr}), 32'h0);
            end else begin
               cur = exp_mem_q.pop_front();
               have_cur = 1'b1;
               check("mem_strobe", 32'({bus.mem_rd, bus.mem_wr}), 32'({~cur.wr, cur.wr}));
               check("mem_addr", bus.mem_addr, cur.addr);
               if (cur.wr) check("mem_wdata", bus.mem_wdata, cur.wdata);
            end
         end
         burst_n++;
         if (have_cur) begin
            if (burst_n > 1) check("mem_addr_stable", bus.mem_addr, cur.addr);
            rdy = (cur.lat == burst_n);
         end
      end else begin
         if (burst_n != 0 && have_cur) check("burst_len", 32'(burst_n), 32'(cur.len));
         burst_n = 0;
         have_cur = 1'b0;
      end
      bus.mem_ready = rdy;
      bus.mem_rdata = rdy ? cur.rdata : Junk;

      if (bus.cpu_done || bus.dma_done) begin
         if (exp_done_q.size() == 0) begin
            check("unexpected_done", 32'({bus.dma_done, bus.cpu_done}), 32'h0);
         end else begin
            de = exp_done_q.pop_front();
            own_act = bus.dma_done;
            check("done_owner", 32'(own_act), 32'(de.own));
            check("done_single", 32'(bus.cpu_done & bus.dma_done), 32'h0);
            if (own_act == OwnCpu) begin
               check("cpu_err", 32'(bus.cpu_err), 32'(de.err));
               check("cpu_gnt", 32'(bus.cpu_gnt), 32'h1);
               if (de.chk_rd) check("cpu_rdata", bus.cpu_rdata, de.rdata);
               check("dma_idle_flags", 32'({bus.dma_gnt, bus.dma_err}), 32'h0);
               check("dma_idle_rdata", bus.dma_rdata, 32'h0);
            end else begin
               check("dma_err", 32'(bus.dma_err), 32'(de.err));
               check("dma_gnt", 32'(bus.dma_gnt), 32'h1);
               if (de.chk_rd) check("dma_rdata", bus.dma_rdata, de.rdata);
               check("cpu_idle_flags", 32'({bus.cpu_gnt, bus.cpu_err}), 32'h0);
               check("cpu_idle_rdata", bus.cpu_rdata, 32'h0);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.cpu_req = 1'b0; bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.dma_req = 1'b0; bus.dma_wr = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
      bus.mem_ready = 1'b0; bus.mem_rdata = Junk;
      fork
         begin
            while (!stop_mon) begin
               @(negedge clk);
               mon_step();
            end
         end
         begin
            repeat (3) @(negedge clk);
            check_quiet("reset");
            reset = 1'b0;

            // cpu read 0x40, ready in BUSY cycle 2
            cpu_seq[0] = '{wr: 1'b0, addr: 32'h40, wdata: 32'h0};
            push_txn(OwnCpu, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 2, 2, 1'b1, 1'b0, 32'hDEAD_BEEF);
            requester(OwnCpu, 1);
            repeat (2) @(negedge clk);

            // simultaneous writes right after reset: cpu first, then dma
            do_reset();
            cpu_seq[0] = '{wr: 1'b1, addr: 32'h10, wdata: 32'h1234_5678};
            dma_seq[0] = '{wr: 1'b1, addr: 32'h20, wdata: 32'hCAFE_0000};
            push_txn(OwnCpu, 1'b1, 32'h10, 32'h1234_5678, 32'h0, 1, 1, 1'b1, 1'b0, 32'h0);
            push_txn(OwnDma, 1'b1, 32'h20, 32'hCAFE_0000, 32'h0, 1, 1, 1'b1, 1'b0, 32'h0);
            fork
               requester(OwnCpu, 1);
               requester(OwnDma, 1);
            join
            repeat (2) @(negedge clk);

            // both hold req for 4 transactions: cpu, dma, cpu, dma
            cpu_seq[0] = '{wr: 1'b0, addr: 32'h100, wdata: 32'h0};
            cpu_seq[1] = '{wr: 1'b0, addr: 32'h104, wdata: 32'h0};
            dma_seq[0] = '{wr: 1'b1, addr: 32'h200, wdata: 32'hA5A5_0001};
            dma_seq[1] = '{wr: 1'b1, addr: 32'h204, wdata: 32'hA5A5_0002};
            push_txn(OwnCpu, 1'b0, 32'h100, 32'h0, 32'h1111_0000, 1, 1, 1'b1, 1'b0, 32'h1111_0000);
            push_txn(OwnDma, 1'b1, 32'h200, 32'hA5A5_0001, 32'h0, 3, 3, 1'b1, 1'b0, 32'h0);
            push_txn(OwnCpu, 1'b0, 32'h104, 32'h0, 32'h3333_0000, 2, 2, 1'b1, 1'b0, 32'h3333_0000);
            push_txn(OwnDma, 1'b1, 32'h204, 32'hA5A5_0002, 32'h0, 1, 1, 1'b1, 1'b0, 32'h0);
            fork
               requester(OwnCpu, 2);
               requester(OwnDma, 2);
            join
            repeat (2) @(negedge clk);

            // dma read never answered: 4 strobe cycles, err=1, rdata=0
            dma_seq[0] = '{wr: 1'b0, addr: 32'h300, wdata: 32'h0};
            push_txn(OwnDma, 1'b0, 32'h300, 32'h0, 32'h0, 0, 4, 1'b1, 1'b1, 32'h0);
            requester(OwnDma, 1);
            @(negedge clk);
            check("idle_after_timeout", 32'({bus.dma_gnt, bus.dma_done, bus.mem_rd, bus.mem_wr}), 32'h0);
            @(negedge clk);

            // ready on the last counter value: ready wins, err=0
            cpu_seq[0] = '{wr: 1'b0, addr: 32'h400, wdata: 32'h0};
            push_txn(OwnCpu, 1'b0, 32'h400, 32'h0, 32'h4444_4444, 4, 4, 1'b1, 1'b0, 32'h4444_4444);
            requester(OwnCpu, 1);
            repeat (2) @(negedge clk);

            // reset in BUSY cycle 2 of a cpu write: abandoned, no done
            push_txn(OwnCpu, 1'b1, 32'h50, 32'h5555_5555, 32'h0, 0, 2, 1'b0, 1'b0, 32'h0);
            bus.cpu_wr = 1'b1; bus.cpu_addr = 32'h50; bus.cpu_wdata = 32'h5555_5555;
            bus.cpu_req = 1'b1;
            repeat (2) @(negedge clk);
            reset = 1'b1;
            bus.cpu_req = 1'b0;
            @(negedge clk);
            check_quiet("midreset");
            reset = 1'b0;
            repeat (3) @(negedge clk);

            // dma changes addr while BUSY: mem_addr holds 0x100
            dma_seq[0] = '{wr: 1'b0, addr: 32'h100, wdata: 32'h0};
            push_txn(OwnDma, 1'b0, 32'h100, 32'h0, 32'h7777_0000, 3, 3, 1'b1, 1'b0, 32'h7777_0000);
            fork
               requester(OwnDma, 1);
               begin
                  repeat (2) @(negedge clk);
                  bus.dma_addr = 32'h200;
                  bus.dma_wr = 1'b1;
               end
            join
            repeat (3) @(negedge clk);

            check("exp_mem_left", 32'(exp_mem_q.size()), 32'h0);
            check("exp_done_left", 32'(exp_done_q.size()), 32'h0);
            stop_mon = 1'b1;
         end
      join
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
      $finish;
   end

endmodule
